// File: rtl/peripheral_fifo_responder.sv
// peripheral_fifo_responder
//   Memory-mapped responder that fronts a small FIFO behind the peripheral bus.
//   Word map: 0 DATA (push/pop), 1 STATUS, 2 CONTROL (flush / clear sticky),
//   3 SCRATCH, 4 THRESH. Read data is registered (one cycle latency).
//   Optional build macro PERIPH_FIFO_IRQ_EN adds the THRESH register and a
//   registered level interrupt; without it THRESH reads 0 and irq is tied 0.
//
// Bus protocol: write_en and read_en are single-cycle strobes with no
// back-pressure; every strobe is accepted in the cycle it is seen. Both may be
// high in one cycle for the same address, in which case both act and the read
// observes the state from before the write.
module peripheral_fifo_responder #(
   parameter int DATAWIDTH    = 32,
   parameter int ADDRESSWIDTH = 4,
   parameter int FIFODEPTH    = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDRESSWIDTH-1:0] address,
   input  logic [DATAWIDTH-1:0]    data_in,
   output logic [DATAWIDTH-1:0]    data_out,
   input  logic                    write_en,
   input  logic                    read_en,
   output logic                    irq
);

   localparam int CW = $clog2(FIFODEPTH + 1);
   localparam int PW = $clog2(FIFODEPTH);

   localparam logic [ADDRESSWIDTH-1:0] A_DATA    = ADDRESSWIDTH'(0);
   localparam logic [ADDRESSWIDTH-1:0] A_STATUS  = ADDRESSWIDTH'(1);
   localparam logic [ADDRESSWIDTH-1:0] A_CONTROL = ADDRESSWIDTH'(2);
   localparam logic [ADDRESSWIDTH-1:0] A_SCRATCH = ADDRESSWIDTH'(3);
   localparam logic [ADDRESSWIDTH-1:0] A_THRESH  = ADDRESSWIDTH'(4);

   logic [DATAWIDTH-1:0] mem [FIFODEPTH];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [CW-1:0]        count;
   logic                 overflow;
   logic                 underflow;
   logic [DATAWIDTH-1:0] scratch;
   logic [DATAWIDTH-1:0] thresh_word;

   logic                 is_empty;
   logic                 is_full;
   logic                 push_req;
   logic                 pop_req;
   logic                 do_push;
   logic                 do_pop;
   logic                 overflow_set;
   logic                 underflow_set;
   logic                 flush;
   logic                 clear_sticky;
   logic [DATAWIDTH-1:0] head_word;
   logic [DATAWIDTH-1:0] status_word;
   logic [DATAWIDTH-1:0] rd_value;

   // Decode strobes into FIFO/control actions; a pop frees the slot a
   // concurrent push needs, so push+pop on a full FIFO both succeed.
   always_comb begin
      is_empty      = (count == '0);
      is_full       = (count == CW'(FIFODEPTH));
      push_req      = write_en && (address == A_DATA);
      pop_req       = read_en  && (address == A_DATA);
      do_pop        = pop_req && !is_empty;
      do_push       = push_req && (!is_full || do_pop);
      overflow_set  = push_req && is_full && !do_pop;
      underflow_set = pop_req && is_empty;
      flush         = write_en && (address == A_CONTROL) && data_in[0];
      clear_sticky  = write_en && (address == A_CONTROL) && data_in[1];
   end

   // Storage array: never reset, flush only moves the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= data_in;
   end

   // Pointers and occupancy count; flush overrides any same-cycle movement.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky error flags: a new event beats a same-cycle clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (overflow  && !clear_sticky) || overflow_set;
         underflow <= (underflow && !clear_sticky) || underflow_set;
      end
   end

   // Scratch register, full width.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) scratch <= '0;
      else if (write_en && (address == A_SCRATCH)) scratch <= data_in;
   end

`ifdef PERIPH_FIFO_IRQ_EN
   logic [CW-1:0] thresh;
   logic          irq_q;

   // Threshold register, low CW bits only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) thresh <= '0;
      else if (write_en && (address == A_THRESH)) thresh <= data_in[CW-1:0];
   end

   // Interrupt follows registered count/flags, so it lags them by one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) irq_q <= 1'b0;
      else       irq_q <= ((count >= thresh) && (thresh != '0)) || overflow;
   end

   assign irq         = irq_q;
   assign thresh_word = DATAWIDTH'(thresh);
`else
   assign irq         = 1'b0;
   assign thresh_word = '0;
`endif

   // Read-side views: head of FIFO (0 when empty) and packed status word.
   always_comb begin
      head_word      = is_empty ? '0 : mem[rd_ptr];
      status_word    = '0;
      status_word[0] = is_empty;
      status_word[1] = is_full;
      status_word[2] = overflow;
      status_word[3] = underflow;
      status_word[4 +: CW] = count;
   end

   // Read mux over the register map; unmapped and CONTROL read as 0.
   always_comb begin
      rd_value = '0;
      case (address)
         A_DATA:    rd_value = head_word;
         A_STATUS:  rd_value = status_word;
         A_SCRATCH: rd_value = scratch;
         A_THRESH:  rd_value = thresh_word;
         default:   rd_value = '0;
      endcase
   end

   // Registered read data, held while read_en is low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        data_out <= '0;
      else if (read_en) data_out <= rd_value;
   end

endmodule
